// File: rtl/sk9822_frame_if.sv
// rtl/sk9822_frame_if.sv - control, pixel RAM read and LED pin signals of the SK9822 frame engine
interface sk9822_frame_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic [4:0]        bright;
    logic              busy;
    logic              done;
    logic              re;
    logic [ADDR_W-1:0] raddr;
    logic [23:0]       rdata;
    logic              led_data;
    logic              led_ck;

    modport slave (
        input  start, bright, rdata,
        output busy, done, re, raddr, led_data, led_ck
    );

    modport master (
        output start, bright, rdata,
        input  busy, done, re, raddr, led_data, led_ck
    );
endinterface

// File: rtl/sk9822_frame.sv
// rtl/sk9822_frame.sv - SK9822/APA102 frame engine: start frame, one word per LED from pixel RAM, end frame
module sk9822_frame #(
    parameter int N_LEDS    = 12,
    parameter int ADDR_W    = 4,
    parameter int CK_DIV    = 1,
    parameter int END_WORDS = 1
) (
    input  logic           ck,
    input  logic           rst,
    sk9822_frame_if.slave  bus
);
    localparam int DIV_W  = $clog2(2 * CK_DIV);
    localparam int WORD_W = (END_WORDS > 1) ? $clog2(END_WORDS) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(2 * CK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HIGH  = DIV_W'(CK_DIV);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(END_WORDS - 1);
    localparam logic [ADDR_W-1:0] LED_LAST  = ADDR_W'(N_LEDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_FRM,
        S_FETCH,
        S_LED_WORD,
        S_END_FRM
    } state_t;

    state_t            state, state_n;
    logic [DIV_W-1:0]  div_cnt, div_n;
    logic [4:0]        bit_cnt, bit_n;
    logic [WORD_W-1:0] word_cnt, word_n;
    logic              fetch_ph, fetch_ph_n;
    logic [31:0]       sr, sr_n;
    logic [4:0]        bright_q, bright_n;
    logic [ADDR_W-1:0] raddr_q, raddr_n;
    logic              led_ck_q, led_ck_n;
    logic              led_data_q, led_data_n;
    logic              re_c, done_c;
    logic              bit_end, word_end, shift_n;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            fetch_ph   <= 1'b0;
            sr         <= '0;
            bright_q   <= '0;
            raddr_q    <= '0;
            led_ck_q   <= 1'b0;
            led_data_q <= 1'b0;
        end else begin
            state      <= state_n;
            div_cnt    <= div_n;
            bit_cnt    <= bit_n;
            word_cnt   <= word_n;
            fetch_ph   <= fetch_ph_n;
            sr         <= sr_n;
            bright_q   <= bright_n;
            raddr_q    <= raddr_n;
            led_ck_q   <= led_ck_n;
            led_data_q <= led_data_n;
        end
    end

    always_comb begin
        state_n    = state;
        div_n      = div_cnt;
        bit_n      = bit_cnt;
        word_n     = word_cnt;
        fetch_ph_n = fetch_ph;
        sr_n       = sr;
        bright_n   = bright_q;
        raddr_n    = raddr_q;
        re_c       = 1'b0;
        done_c     = 1'b0;
        bit_end    = (div_cnt == DIV_LAST);
        word_end   = bit_end && (bit_cnt == 5'd31);

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_n  = S_START_FRM;
                    bright_n = bus.bright;
                    sr_n     = '0;
                    div_n    = '0;
                    bit_n    = '0;
                end
            end
            S_START_FRM, S_LED_WORD, S_END_FRM: begin
                // A bit ends after its high phase; the next bit's data appears as led_ck drops.
                if (bit_end) begin
                    div_n = '0;
                    bit_n = bit_cnt + 5'd1;
                    sr_n  = {sr[30:0], 1'b0};
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
                if (word_end) begin
                    case (state)
                        S_START_FRM: begin
                            state_n    = S_FETCH;
                            fetch_ph_n = 1'b0;
                            raddr_n    = '0;
                        end
                        S_LED_WORD: begin
                            if (raddr_q == LED_LAST) begin
                                state_n = S_END_FRM;
                                sr_n    = '1;
                                word_n  = '0;
                            end else begin
                                state_n    = S_FETCH;
                                fetch_ph_n = 1'b0;
                                raddr_n    = raddr_q + ADDR_W'(1);
                            end
                        end
                        default: begin
                            if (word_cnt == WORD_LAST) begin
                                state_n = S_IDLE;
                                done_c  = 1'b1;
                            end else begin
                                word_n = word_cnt + WORD_W'(1);
                                sr_n   = '1;
                            end
                        end
                    endcase
                end
            end
            S_FETCH: begin
                if (!fetch_ph) begin
                    re_c       = 1'b1;
                    fetch_ph_n = 1'b1;
                end else begin
                    state_n = S_LED_WORD;
                    sr_n    = {3'b111, bright_q, bus.rdata};
                    div_n   = '0;
                    bit_n   = '0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Pins are registered copies of what the next state implies, so they never glitch.
        shift_n    = (state_n == S_START_FRM) || (state_n == S_LED_WORD) || (state_n == S_END_FRM);
        led_ck_n   = shift_n && (div_n >= DIV_HIGH);
        led_data_n = shift_n && sr_n[31];
    end

    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = done_c;
    assign bus.re       = re_c;
    assign bus.raddr    = raddr_q;
    assign bus.led_ck   = led_ck_q;
    assign bus.led_data = led_data_q;
endmodule

// File: tb/tb_sk9822_frame.sv
// tb/tb_sk9822_frame.sv - randomized scoreboard bench for sk9822_frame
module tb_sk9822_frame;
    localparam int N_LEDS    = 3;
    localparam int ADDR_W    = 2;
    localparam int CK_DIV    = 2;
    localparam int END_WORDS = 2;
    localparam int LEN       = 64 * CK_DIV * (N_LEDS + 1 + END_WORDS) + 2 * N_LEDS;

    logic ck = 1'b0;
    logic rst = 1'b1;

    sk9822_frame_if #(.ADDR_W(ADDR_W)) bus ();

    sk9822_frame #(
        .N_LEDS(N_LEDS), .ADDR_W(ADDR_W), .CK_DIV(CK_DIV), .END_WORDS(END_WORDS)
    ) dut (
        .ck(ck),
        .rst(rst),
        .bus(bus)
    );

    always #5 ck = ~ck;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    logic [23:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge ck) if (bus.re) bus.rdata <= ram[bus.raddr];

    logic [31:0] exp_words[$];
    int          exp_addr[$];
    int          exp_len[$];

    task automatic push_frame(input logic [4:0] b);
        exp_words.push_back(32'h0000_0000);
        for (int i = 0; i < N_LEDS; i++) begin
            exp_words.push_back({3'b111, b, ram[i]});
            exp_addr.push_back(i);
        end
        for (int i = 0; i < END_WORDS; i++) exp_words.push_back(32'hFFFF_FFFF);
        exp_len.push_back(LEN);
    endtask

    logic [31:0] mword;
    int   nb, busy_len, done_cnt, hi_len, lo_len;
    logic prev_ck, prev_busy, prev_done, prev_data, fetch_seen;

    always @(negedge ck) begin
        if (rst) begin
            mword = '0; nb = 0; busy_len = 0; done_cnt = 0; hi_len = 0; lo_len = 0;
            prev_ck = 0; prev_busy = 0; prev_done = 0; prev_data = 0; fetch_seen = 0;
        end else begin
            if (bus.busy) busy_len++;
            if (bus.done) begin
                check("done_while_busy", bus.busy, 1);
                done_cnt++;
            end
            if (prev_busy && !bus.busy) begin
                if (exp_len.size() == 0) check("unexpected_frame", 1, 0);
                else check("busy_length", busy_len, exp_len.pop_front());
                check("done_pulses", done_cnt, 1);
                check("done_on_last_busy", prev_done, 1);
                check("partial_word_bits", nb, 0);
                busy_len = 0;
                done_cnt = 0;
            end
            if (!bus.busy) check("idle_pins", {bus.led_ck, bus.led_data, bus.re}, 0);
            if (bus.re) begin
                check("led_ck_low_in_fetch", bus.led_ck, 0);
                fetch_seen = 1;
                if (exp_addr.size() == 0) check("unexpected_read", 1, 0);
                else check("raddr", bus.raddr, exp_addr.pop_front());
            end
            if (bus.busy && !bus.led_ck) lo_len++;
            if (bus.led_ck && !prev_ck) begin
                check("low_phase", lo_len, CK_DIV + (fetch_seen ? 2 : 0));
                lo_len = 0;
                fetch_seen = 0;
                mword = {mword[30:0], bus.led_data};
                nb++;
                if (nb == 32) begin
                    if (exp_words.size() == 0) check("unexpected_word", 1, 0);
                    else check("led_word", mword, exp_words.pop_front());
                    nb = 0;
                end
            end
            if (bus.led_ck && prev_ck) check("data_stable_high", bus.led_data, prev_data);
            if (bus.led_ck) hi_len++;
            else if (prev_ck) begin
                check("high_phase", hi_len, CK_DIV);
                hi_len = 0;
            end
            prev_ck   = bus.led_ck;
            prev_busy = bus.busy;
            prev_done = bus.done;
            prev_data = bus.led_data;
        end
    end

    task automatic rand_ram();
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 24'($urandom);
    endtask

    task automatic start_frame(input logic [4:0] b);
        @(negedge ck);
        bus.start  = 1'b1;
        bus.bright = b;
        push_frame(b);
        @(negedge ck);
        bus.start  = 1'b0;
        bus.bright = 5'($urandom);
        check("busy_after_start", bus.busy, 1);
    endtask

    task automatic mid_start();
        repeat ($urandom_range(10, 600)) @(negedge ck);
        bus.start  = 1'b1;
        bus.bright = 5'h01;
        @(negedge ck);
        bus.start  = 1'b0;
    endtask

    task automatic wait_done();
        bit got = 0;
        for (int c = 0; c < LEN + 20 && !got; c++) begin
            @(negedge ck);
            if (bus.done) got = 1;
        end
        check("done_seen", got, 1);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.bright = 5'h00;
        repeat (3) @(negedge ck);
        check("reset_outputs", {bus.busy, bus.done, bus.re, bus.raddr, bus.led_data, bus.led_ck}, 0);
        rst = 1'b0;
        @(negedge ck);
        check("idle_after_reset", bus.busy, 0);

        rand_ram();
        start_frame(5'h1F);
        mid_start();
        wait_done();
        @(negedge ck);

        for (int f = 0; f < 3; f++) begin
            rand_ram();
            start_frame(5'($urandom));
            mid_start();
            wait_done();
            @(negedge ck);
        end

        // Mid-frame asynchronous reset during the second LED word.
        rand_ram();
        start_frame(5'h1F);
        repeat (2 * (64 * CK_DIV + 2) + 30) @(negedge ck);
        @(posedge ck);
        #2 rst = 1'b1;
        #1 check("reset_mid_frame", {bus.busy, bus.done, bus.re, bus.raddr, bus.led_data, bus.led_ck}, 0);
        @(negedge ck);
        exp_words.delete();
        exp_addr.delete();
        exp_len.delete();
        @(negedge ck);
        rst = 1'b0;
        start_frame(5'h1F);
        mid_start();
        wait_done();
        @(negedge ck);

        // Back-to-back: start held through the done cycle and the following idle cycle.
        begin
            logic [4:0] b;
            b = 5'($urandom);
            rand_ram();
            start_frame(b);
            mid_start();
            wait_done();
            bus.start  = 1'b1;
            bus.bright = b;
            push_frame(b);
            @(negedge ck);
            check("idle_between_frames", bus.busy, 0);
            @(negedge ck);
            bus.start  = 1'b0;
            bus.bright = 5'($urandom);
            check("back_to_back_busy", bus.busy, 1);
            wait_done();
            @(negedge ck);
        end

        repeat (5) @(negedge ck);
        check("words_left", exp_words.size(), 0);
        check("reads_left", exp_addr.size(), 0);
        check("frames_left", exp_len.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sk9822_frame.md
Name: sk9822_frame

Overview:
Parametrised SK9822/APA102 frame engine. On a start pulse it sends one complete LED frame: a 32-bit zero start frame, one 32-bit word per LED, then an all-ones end frame. Each LED word is built from a 24-bit pixel read out of an external synchronous dual-port RAM plus a 5-bit global brightness. The block drives the serial data and clock pins directly and sits between the pixel RAM and the LED strip.

Parameters:
- N_LEDS, 12, number of LEDs in the chain; 1 <= N_LEDS <= 2**ADDR_W.
- ADDR_W, 4, width of the pixel RAM read address.
- CK_DIV, 1, system clocks per half-period of led_ck; must be >= 1.
- END_WORDS, 1, number of 32-bit all-ones words in the end frame; must be >= 1.

Ports:
- ck  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request one frame; sampled only in IDLE.
- bright  in  5  global brightness; sampled on the cycle start is accepted.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse on the last busy cycle.
- re  out  1  pixel RAM read enable, one-cycle pulse.
- raddr  out  ADDR_W  pixel RAM read address.
- rdata  in  24  pixel data, valid the cycle after re; passed through unmodified.
- led_data  out  1  serial data, MSB first.
- led_ck  out  1  serial clock, idle low.

Behaviour:
- Reset, asynchronous and immediate, including mid-frame:
  - busy = 0, done = 0, re = 0, raddr = 0, led_data = 0, led_ck = 0.
  - FSM goes to IDLE; the brightness latch clears to 0.
- FSM states: IDLE -> START_FRM -> (FETCH -> LED_WORD) x N_LEDS -> END_FRM -> IDLE.
- IDLE:
  - start = 1 latches bright, sets busy on the next edge and enters START_FRM.
  - start while busy is ignored; there is no queueing.
  - start on the same cycle as done is ignored; the first start that can be accepted is on the following (idle) cycle.
- Bit timing:
  - Each bit lasts 2*CK_DIV cycles: led_ck low for CK_DIV cycles, then high for CK_DIV cycles.
  - led_data changes only on the edge where led_ck goes low, or at word load. It is stable for the whole high phase.
  - 32 bits per word; the shift register is 32 bits wide.
- START_FRM: shifts 32'h0000_0000.
- FETCH (2 cycles, led_ck held low):
  - Cycle 1: re = 1, raddr = LED index.
  - Cycle 2: capture rdata and load {3'b111, bright_latched, rdata}.
- LED_WORD:
  - Shifts the loaded word.
  - LED index counts 0..N_LEDS-1 and never reaches N_LEDS on raddr.
  - After the last LED, go to END_FRM.
- END_FRM: shifts END_WORDS*32 ones, then returns to IDLE.
  - led_ck = 0 and led_data = 0 on return.
  - done pulses on the final busy cycle; busy falls on the next edge.
- Frame length: busy is high for exactly 64*CK_DIV*(N_LEDS+1+END_WORDS) + 2*N_LEDS cycles.
- The bright input may change freely mid-frame; only the latched value is used.
- re is never asserted outside FETCH. raddr holds its last value between reads.

Test Plan:
- Reset mid-frame: assert rst asynchronously during an LED word -> all outputs 0 immediately. After rst release, start -> a clean full frame from its start frame.
- Frame content: N_LEDS=2, CK_DIV=1, END_WORDS=1, RAM[0]=24'h0000FF, RAM[1]=24'h123456, bright=5'h1F.
  - Sampling led_data on led_ck rising edges gives 32'h00000000, 32'hFF0000FF, 32'hFF123456, 32'hFFFFFFFF.
  - busy is high for 260 cycles; exactly one done pulse.
- Clock divider: CK_DIV=3 -> led_ck high 3 and low 3 cycles per bit. led_data never changes while led_ck is high. busy length matches the formula.
- Ignored inputs: start pulsed mid-frame and at done -> ignored. bright changed to 5'h01 mid-frame -> every LED word still carries 5'h1F (top byte 0xFF).
- Read sequence: default parameters -> re pulses exactly 12 times with raddr 0..11 in order. raddr never equals 12. led_ck is low during every FETCH.
- Back-to-back: start pulsed on the idle cycle right after done -> the second frame is bit-identical to the first, with no extra led_ck edges between frames.
